// File: rtl/ssd_pkg.sv
// ssd_pkg -- shared definitions for the seven-segment scan driver.
//   Segment order on the bus is {g,c,b,a,f,e,d} (bit6..bit0), active-high.
//   GLYPH_0..GLYPH_9 : digit patterns; GLYPH_BLANK : all segments off.
//   SEG_G..SEG_D     : bit positions of each segment within the 7-bit word.
//   bcd_to_seg()     : nibble -> glyph; codes 10..15 map to GLYPH_BLANK.
package ssd_pkg;

    localparam int SEG_G = 6;
    localparam int SEG_C = 5;
    localparam int SEG_B = 4;
    localparam int SEG_A = 3;
    localparam int SEG_F = 2;
    localparam int SEG_E = 1;
    localparam int SEG_D = 0;

    localparam logic [6:0] GLYPH_0     = 7'b0111111;
    localparam logic [6:0] GLYPH_1     = 7'b0110000;
    localparam logic [6:0] GLYPH_2     = 7'b1011011;
    localparam logic [6:0] GLYPH_3     = 7'b1111001;
    localparam logic [6:0] GLYPH_4     = 7'b1110100;
    localparam logic [6:0] GLYPH_5     = 7'b1101101;
    localparam logic [6:0] GLYPH_6     = 7'b1100111;
    localparam logic [6:0] GLYPH_7     = 7'b0111000;
    localparam logic [6:0] GLYPH_8     = 7'b1111111;
    localparam logic [6:0] GLYPH_9     = 7'b1111101;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    // Non-decimal codes fall through to the blank glyph so the pins never see X.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = GLYPH_0;
            4'd1:    seg = GLYPH_1;
            4'd2:    seg = GLYPH_2;
            4'd3:    seg = GLYPH_3;
            4'd4:    seg = GLYPH_4;
            4'd5:    seg = GLYPH_5;
            4'd6:    seg = GLYPH_6;
            4'd7:    seg = GLYPH_7;
            4'd8:    seg = GLYPH_8;
            4'd9:    seg = GLYPH_9;
            default: seg = GLYPH_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_scan_mux_if.sv
// ssd_scan_mux_if -- load handshake plus display pins of the scan driver.
//   load_valid/load_ready/load_data : packed-BCD load handshake (nibble k -> digit k)
//   blank_mask                      : live per-digit force-dark mask
//   seg_out/dig_en/frame_done       : segment pins, one-hot digit enables, frame pulse
//   master : producer of loads / consumer of pins; slave : the scan driver.
interface ssd_scan_mux_if #(
    parameter int DIGITS = 4
);

    logic                  load_valid;
    logic                  load_ready;
    logic [4*DIGITS-1:0]   load_data;
    logic [DIGITS-1:0]     blank_mask;
    logic [6:0]            seg_out;
    logic [DIGITS-1:0]     dig_en;
    logic                  frame_done;

    modport master (
        output load_valid, load_data, blank_mask,
        input  load_ready, seg_out, dig_en, frame_done
    );

    modport slave (
        input  load_valid, load_data, blank_mask,
        output load_ready, seg_out, dig_en, frame_done
    );

endinterface

// File: rtl/ssd_glyph.sv
// ssd_glyph -- combinational BCD nibble to seven-segment glyph.
//   nib : 4-bit code in
//   seg : 7-bit active-high glyph {g,c,b,a,f,e,d}; codes 10..15 give all-off.
module ssd_glyph
    import ssd_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Look up the glyph for the selected nibble.
    always_comb begin
        seg = bcd_to_seg(nib);
    end

endmodule

// File: rtl/ssd_scan_mux.sv
// ssd_scan_mux -- time-multiplexed driver for a DIGITS-wide common-cathode
// seven-segment bank with a double-buffered load path.
//   clk, rst : clock; asynchronous active-high reset
//   bus      : ssd_scan_mux_if.slave (load handshake, blank_mask, seg_out,
//              dig_en, frame_done)
// A load lands in a pending buffer and is copied to the display register only
// at a frame end, so a frame never mixes old and new digits. Each digit slot
// lasts CLK_DIV cycles and starts with BLANK_CYC dark cycles to hide ghosting.
// Optional macro SSD_LEADING_ZERO_BLANK_EN: digits above 0 that belong to a run
// of leading zeros are darkened as if masked.
module ssd_scan_mux
    import ssd_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 1
) (
    input  logic          clk,
    input  logic          rst,
    ssd_scan_mux_if.slave bus
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (DIGITS  > 1) ? $clog2(DIGITS)  : 1;
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0]    div_cnt_r;
    logic [IDX_W-1:0]    dig_idx_r;
    logic [4*DIGITS-1:0] display_r;
    logic [4*DIGITS-1:0] pending_r;
    logic                pend_empty_r;
    logic [6:0]          seg_r;
    logic [DIGITS-1:0]   dig_en_r;
    logic                frame_done_r;

    logic                slot_term_s;
    logic                frame_term_s;
    logic                accept_s;
    logic [3:0]          nib_s;
    logic [6:0]          glyph_s;
    logic [DIGITS-1:0]   onehot_s;
    logic [DIGITS-1:0]   auto_blank_s;
    logic                in_blank_s;
    logic                dark_s;

    // Slot/frame terminal decode and handshake acceptance.
    always_comb begin
        slot_term_s  = (div_cnt_r == DIV_LAST);
        frame_term_s = slot_term_s && (dig_idx_r == IDX_LAST);
        accept_s     = bus.load_valid && pend_empty_r;
    end

    // Slot divider and digit index; the index only moves on a slot terminal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= {CNT_W{1'b0}};
            dig_idx_r <= {IDX_W{1'b0}};
        end else if (slot_term_s) begin
            div_cnt_r <= {CNT_W{1'b0}};
            if (dig_idx_r == IDX_LAST) begin
                dig_idx_r <= {IDX_W{1'b0}};
            end else begin
                dig_idx_r <= dig_idx_r + 1'b1;
            end
        end else begin
            div_cnt_r <= div_cnt_r + 1'b1;
        end
    end

    // Double buffer: commit at frame end, otherwise accept into an empty buffer.
    // The two branches are exclusive because a commit needs a full buffer and an
    // accept needs an empty one, so a load taken on the frame-end edge waits a
    // whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            display_r    <= {(4*DIGITS){1'b0}};
            pending_r    <= {(4*DIGITS){1'b0}};
            pend_empty_r <= 1'b1;
        end else if (frame_term_s && !pend_empty_r) begin
            display_r    <= pending_r;
            pend_empty_r <= 1'b1;
        end else if (accept_s) begin
            pending_r    <= bus.load_data;
            pend_empty_r <= 1'b0;
        end else begin
            pend_empty_r <= pend_empty_r;
        end
    end

    // Pick the nibble of the digit currently being scanned.
    always_comb begin
        nib_s = display_r[{dig_idx_r, 2'b00} +: 4];
    end

    ssd_glyph u_glyph (
        .nib (nib_s),
        .seg (glyph_s)
    );

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; a digit is auto-blanked while it and all
    // digits above it are zero. Digit 0 is excluded so an all-zero word shows "0".
    always_comb begin : lz_scan
        logic zero_run;
        zero_run     = 1'b1;
        auto_blank_s = {DIGITS{1'b0}};
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run        = zero_run & (display_r[4*k +: 4] == 4'h0);
            auto_blank_s[k] = zero_run;
        end
    end
`else
    assign auto_blank_s = {DIGITS{1'b0}};
`endif

    // Ghost-suppression window at the head of every slot (none when BLANK_CYC is 0).
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign in_blank_s = 1'b0;
        end else begin : g_blank
            assign in_blank_s = (div_cnt_r < BLANK_END);
        end
    endgenerate

    // One-hot enable for the current digit and the combined dark condition.
    always_comb begin
        onehot_s            = {DIGITS{1'b0}};
        onehot_s[dig_idx_r] = 1'b1;
        dark_s              = in_blank_s || bus.blank_mask[dig_idx_r] ||
                              auto_blank_s[dig_idx_r];
    end

    // Registered pin drivers; one cycle behind the slot counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r        <= 7'b0000000;
            dig_en_r     <= {DIGITS{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= frame_term_s;
            if (dark_s) begin
                seg_r    <= 7'b0000000;
                dig_en_r <= {DIGITS{1'b0}};
            end else begin
                seg_r    <= glyph_s;
                dig_en_r <= onehot_s;
            end
        end
    end

    assign bus.load_ready = pend_empty_r;
    assign bus.seg_out    = seg_r;
    assign bus.dig_en     = dig_en_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// tb_ssd_scan_mux -- scoreboard bench for ssd_scan_mux (DIGITS=4, CLK_DIV=4,
// BLANK_CYC=1). A reference model, driven by the elapsed cycle count since
// reset, pushes the expected pin state after each rising edge into a queue; a
// monitor pops one entry per cycle and compares it with the DUT pins.
// Honours SSD_LEADING_ZERO_BLANK_EN in the model when the macro is defined.
module tb_ssd_scan_mux;

    localparam int DIGITS    = 4;
    localparam int CLK_DIV   = 4;
    localparam int BLANK_CYC = 1;
    localparam int FRAME     = DIGITS * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ssd_scan_mux_if #(.DIGITS(DIGITS)) bus ();

    ssd_scan_mux #(
        .DIGITS    (DIGITS),
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [6:0]        seg;
        logic [DIGITS-1:0] en;
        logic              fd;
        logic              rdy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [6:0] glyph_tbl [16];

    // reference model state
    int          cyc;
    int          m_div;
    int          m_dg;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_full;
    bit          m_dark;
    bit          m_accept;
    bit          lz_en;
    exp_t        m_e;
    exp_t        mon_e;

    initial begin
        glyph_tbl = '{7'b0111111, 7'b0110000, 7'b1011011, 7'b1111001,
                      7'b1110100, 7'b1101101, 7'b1100111, 7'b0111000,
                      7'b1111111, 7'b1111101, 7'b0000000, 7'b0000000,
                      7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
`ifdef SSD_LEADING_ZERO_BLANK_EN
        lz_en = 1'b1;
`else
        lz_en = 1'b0;
`endif
    end

    // Reference model: state index cyc counts edges since reset release.
    initial begin
        cyc    = 0;
        m_disp = 16'h0000;
        m_pend = 16'h0000;
        m_full = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                cyc    = 0;
                m_disp = 16'h0000;
                m_pend = 16'h0000;
                m_full = 1'b0;
                m_e    = '{seg: 7'b0, en: 4'b0, fd: 1'b0, rdy: 1'b1};
            end else begin
                m_div  = cyc % CLK_DIV;
                m_dg   = (cyc / CLK_DIV) % DIGITS;
                m_dark = (m_div < BLANK_CYC) || bus.blank_mask[m_dg] ||
                         (lz_en && m_dg > 0 && (m_disp >> (4 * m_dg)) == 16'h0000);
                m_e.seg = m_dark ? 7'b0 : glyph_tbl[m_disp[m_dg*4 +: 4]];
                m_e.en  = m_dark ? 4'b0 : 4'(1 << m_dg);
                m_e.fd  = ((cyc % FRAME) == FRAME - 1);
                m_accept = bus.load_valid && !m_full;
                if (m_e.fd && m_full) begin
                    m_disp = m_pend;
                    m_full = 1'b0;
                end
                if (m_accept) begin
                    m_pend = bus.load_data;
                    m_full = 1'b1;
                end
                m_e.rdy = !m_full;
                cyc++;
            end
            exp_q.push_back(m_e);
        end
    end

    // Monitor: one expected entry per rising edge, checked 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty @%0t: no expected entry queued", $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.seg_out !== mon_e.seg || bus.dig_en !== mon_e.en ||
                    bus.frame_done !== mon_e.fd || bus.load_ready !== mon_e.rdy) begin
                    n_bad++;
                    $display("FAIL pins @%0t: got seg=%b en=%b fd=%b rdy=%b, expected seg=%b en=%b fd=%b rdy=%b",
                             $time, bus.seg_out, bus.dig_en, bus.frame_done, bus.load_ready,
                             mon_e.seg, mon_e.en, mon_e.fd, mon_e.rdy);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer a word and hold it until one accepting edge has passed (bounded wait).
    task automatic send(input logic [15:0] d);
        bit ok;
        ok             = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        for (int i = 0; i < 64; i++) begin
            if (bus.load_ready === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.load_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL send_timeout data=%h: load_ready=%b, expected 1 within 64 cycles",
                     d, bus.load_ready);
        end
    endtask

    // Stimulus
    initial begin
        bus.load_valid = 1'b0;
        bus.load_data  = 16'h0000;
        bus.blank_mask = 4'b0000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(40);

        send(16'h1234);
        idle(40);

        // second load offered while the first is still pending
        send(16'h0A21);
        send(16'h5678);
        idle(40);

        bus.blank_mask = 4'b0010;
        idle(20);
        bus.blank_mask = 4'b0000;

        // reset mid-frame with the pending buffer full
        send(16'h4321);
        idle(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(40);

        send(16'h0050);
        idle(40);
        send(16'h0000);
        idle(40);

        for (int i = 0; i < 300; i++) begin
            bus.load_valid = 1'($urandom_range(0, 1));
            bus.load_data  = 16'($urandom);
            bus.blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            rst            = ($urandom_range(0, 60) == 0) ? 1'b1 : 1'b0;
            idle($urandom_range(1, 6));
        end

        rst            = 1'b0;
        bus.load_valid = 1'b0;
        bus.blank_mask = 4'b0000;
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
